// File: rtl/hk628_pkg.sv
// Shared types and constants for the HK628 voice trigger scheduler.
package hk628_pkg;

  localparam int ID_W = 4;
  localparam logic [ID_W-1:0] LOW_BATT_ID = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    PLAY
  } sched_state_t;

endpackage

// File: rtl/hk628_debounce.sv
// One input channel: 2-flop synchronizer, sample-tick debounce counter and
// a one-cycle pulse on each rising edge of the debounced level.
module hk628_debounce
  import hk628_pkg::*;
#(
  parameter int DEB_TICKS = 480,
  parameter int CNT_W     = 9
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  input  logic sample_tick,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_TICKS - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             rise_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      rise_reg  <= 1'b0;
      if (sample_tick) begin
        if (sync2_reg == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg >= CNT_LAST) begin
          // DEB_TICKS-th consecutive differing sample: accept the new level
          level_reg <= sync2_reg;
          rise_reg  <= sync2_reg;
          cnt_reg   <= '0;
        end else if (cnt_reg != '1) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/hk628_voice_sched.sv
// Debounces the sound/low-battery buttons, queues presses and arbitrates them
// onto the single playback voice via req/ack/done, with abort and watchdog.
module hk628_voice_sched
  import hk628_pkg::*;
#(
  parameter int NUM_BTN        = 8,
  parameter int CLK_DIV        = 1042,
  parameter int DEB_TICKS      = 480,
  parameter int MAX_PLAY_TICKS = 240000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               low_batt_btn,
  output logic               sample_tick,
  output logic               play_req,
  output logic [ID_W-1:0]    play_id,
  input  logic               play_ack,
  input  logic               play_done,
  output logic               abort,
  output logic [NUM_BTN:0]   pending,
  output logic               timeout_err
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int LG_W  = $clog2(NUM_BTN);
  localparam int WD_W  = 18;

  // ---------------- sample tick divider ----------------
  logic [DIV_W-1:0] div_reg;
  logic             tick_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (div_reg == DIV_W'(CLK_DIV - 1)) begin
      div_reg  <= '0;
      tick_reg <= 1'b1;
    end else begin
      div_reg  <= div_reg + 1'b1;
      tick_reg <= 1'b0;
    end
  end

  assign sample_tick = tick_reg;

  // ---------------- input conditioning ----------------
  logic [NUM_BTN:0] raw_all;
  logic [NUM_BTN:0] rise;

  assign raw_all = {low_batt_btn, btn};

  for (genvar gi = 0; gi <= NUM_BTN; gi++) begin : g_deb
    hk628_debounce #(
      .DEB_TICKS(DEB_TICKS)
    ) u_deb (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw        (raw_all[gi]),
      .sample_tick(tick_reg),
      .rise       (rise[gi])
    );
  end

  // ---------------- scheduler state ----------------
  sched_state_t     state_reg, state_next;
  logic             req_reg, req_next;
  logic [ID_W-1:0]  id_reg, id_next;
  logic             abort_reg, abort_next;
  logic             terr_reg, terr_next;
  logic [LG_W-1:0]  last_granted_reg, last_granted_next;
  logic [WD_W-1:0]  wd_reg, wd_next;
  logic [NUM_BTN:0] pending_reg, pending_next;
  logic [NUM_BTN:0] clr_mask;

  // ---------------- arbiter ----------------
  logic [ID_W-1:0] winner;
  logic [LG_W-1:0] idx;

  always_comb begin
    winner = LOW_BATT_ID;
    idx    = '0;
    if (!pending_reg[NUM_BTN]) begin
      winner = '0;
      // Walk offsets from farthest to nearest so last_granted+1 ends up winning
      for (int k = NUM_BTN; k >= 1; k--) begin
        idx = last_granted_reg + LG_W'(k);
        if (pending_reg[idx]) begin
          winner = ID_W'(idx);
        end
      end
    end
  end

  // ---------------- next-state logic ----------------
  logic retrig_same;
  logic lb_preempt;
  logic wd_expire;

  assign retrig_same = rise[id_reg];
  assign lb_preempt  = rise[NUM_BTN] && (id_reg != LOW_BATT_ID);
  assign wd_expire   = tick_reg && (wd_reg == WD_W'(MAX_PLAY_TICKS - 1));

  always_comb begin
    state_next        = state_reg;
    req_next          = req_reg;
    id_next           = id_reg;
    abort_next        = 1'b0;
    terr_next         = terr_reg;
    last_granted_next = last_granted_reg;
    wd_next           = wd_reg;
    clr_mask          = '0;

    case (state_reg)
      IDLE: begin
        if (|pending_reg) begin
          id_next    = winner;
          req_next   = 1'b1;
          state_next = REQ;
        end
      end

      REQ: begin
        if (play_ack) begin
          clr_mask[id_reg] = 1'b1;
          req_next         = 1'b0;
          if (id_reg != LOW_BATT_ID) begin
            last_granted_next = id_reg[LG_W-1:0];
          end
          wd_next    = '0;
          state_next = PLAY;
        end
      end

      PLAY: begin
        if (tick_reg) begin
          wd_next = wd_reg + 1'b1;
        end
        // Retrigger outranks done, which in turn outranks the watchdog
        if (lb_preempt || retrig_same) begin
          abort_next = 1'b1;
          id_next    = lb_preempt ? LOW_BATT_ID : id_reg;
          req_next   = 1'b1;
          state_next = REQ;
        end else if (play_done) begin
          state_next = IDLE;
        end else if (wd_expire) begin
          abort_next = 1'b1;
          terr_next  = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase

    pending_next = (pending_reg & ~clr_mask) | rise;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      req_reg          <= 1'b0;
      id_reg           <= '0;
      abort_reg        <= 1'b0;
      terr_reg         <= 1'b0;
      last_granted_reg <= LG_W'(NUM_BTN - 1);
      wd_reg           <= '0;
      pending_reg      <= '0;
    end else begin
      state_reg        <= state_next;
      req_reg          <= req_next;
      id_reg           <= id_next;
      abort_reg        <= abort_next;
      terr_reg         <= terr_next;
      last_granted_reg <= last_granted_next;
      wd_reg           <= wd_next;
      pending_reg      <= pending_next;
    end
  end

  assign play_req    = req_reg;
  assign play_id     = id_reg;
  assign abort       = abort_reg;
  assign pending     = pending_reg;
  assign timeout_err = terr_reg;

endmodule

// File: tb/tb_hk628_voice_sched.sv
// Scoreboard bench for hk628_voice_sched: expected grants are queued as
// stimulus is driven and compared whenever play_req rises.
module tb_hk628_voice_sched;

  localparam int NUM_BTN        = 8;
  localparam int CLK_DIV        = 4;
  localparam int DEB_TICKS      = 4;
  localparam int MAX_PLAY_TICKS = 16;
  localparam int SETTLE         = (DEB_TICKS + 2) * CLK_DIV + 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NUM_BTN-1:0] btn;
  logic               low_batt_btn;
  logic               sample_tick;
  logic               play_req;
  logic [3:0]         play_id;
  logic               play_ack;
  logic               play_done;
  logic               abort;
  logic [NUM_BTN:0]   pending;
  logic               timeout_err;

  hk628_voice_sched #(
    .NUM_BTN       (NUM_BTN),
    .CLK_DIV       (CLK_DIV),
    .DEB_TICKS     (DEB_TICKS),
    .MAX_PLAY_TICKS(MAX_PLAY_TICKS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn         (btn),
    .low_batt_btn(low_batt_btn),
    .sample_tick (sample_tick),
    .play_req    (play_req),
    .play_id     (play_id),
    .play_ack    (play_ack),
    .play_done   (play_done),
    .abort       (abort),
    .pending     (pending),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int abrt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   abort_cnt = 0;
  logic req_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int id, input int abrt);
    exp_t e;
    e.id   = id;
    e.abrt = abrt;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Grant monitor: pops the scoreboard on every rising play_req
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (abort) abort_cnt++;
    if (reset_n && play_req && !req_prev) begin
      $display("[TB] grant id=%0d abort=%0b cyc=%0d", play_id, abort, cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_req", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("grant_id", play_id, e.id);
        chk("grant_abort", abort, e.abrt);
      end
    end
    req_prev = play_req;
  end

  task automatic wait_req(input int limit);
    int n = 0;
    while (!play_req && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!play_req) chk("req_wait_timeout", 0, 1);
  endtask

  task automatic ack_req(input int id);
    wait_req(50);
    play_ack = 1'b1;
    @(negedge clk);
    play_ack = 1'b0;
    $display("[TB] ack id=%0d cyc=%0d", id, cyc);
    chk("ack_req_drop", play_req, 0);
    chk("ack_pending_clr", pending[id], 0);
  endtask

  task automatic done_pulse();
    play_done = 1'b1;
    @(negedge clk);
    play_done = 1'b0;
    $display("[TB] done cyc=%0d", cyc);
  endtask

  task automatic settle();
    repeat (SETTLE) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got 1 expected 0");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int t0;
    int lat;
    int a0;

    btn          = '0;
    low_batt_btn = 1'b0;
    play_ack     = 1'b0;
    play_done    = 1'b0;
    reset_n      = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_play_req", play_req, 0);
    chk("rst_abort", abort, 0);
    chk("rst_play_id", play_id, 0);
    chk("rst_pending", pending, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_sample_tick", sample_tick, 0);

    // Divider: first tick CLK_DIV cycles after release, then every CLK_DIV
    reset_n = 1'b1;
    n = 0;
    while (!sample_tick && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("tick_first", n, CLK_DIV);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 100);
    chk("tick_period", n, CLK_DIV);

    // Bouncing btn[3], then held: exactly one grant of id 3
    for (int i = 0; i < 4; i++) begin
      btn[3] = 1'b1;
      repeat ($urandom_range(1, 2)) @(negedge clk);
      btn[3] = 1'b0;
      repeat (CLK_DIV + 2) @(negedge clk);
    end
    btn[3] = 1'b1;
    t0 = cyc;
    push_exp(3, 0);
    wait_req(200);
    lat = cyc - t0;
    $display("[TB] press latency=%0d cycles", lat);
    chk("deb_latency_in_range",
        int'(lat >= (DEB_TICKS - 1) * CLK_DIV + 2 && lat <= DEB_TICKS * CLK_DIV + 4), 1);
    ack_req(3);
    done_pulse();
    repeat (4) @(negedge clk);
    chk("idle_after_done", play_req, 0);
    btn[3] = 1'b0;
    settle();

    // Round robin: make last_granted=4, then 0/5/6 together -> 5, 6, 0
    btn[4] = 1'b1;
    push_exp(4, 0);
    wait_req(200);
    ack_req(4);
    done_pulse();
    btn[4] = 1'b0;
    settle();
    btn[0] = 1'b1;
    btn[5] = 1'b1;
    btn[6] = 1'b1;
    push_exp(5, 0);
    push_exp(6, 0);
    push_exp(0, 0);
    wait_req(200);
    chk("rr_all_pending", pending, 9'h061);
    ack_req(5);
    done_pulse();
    ack_req(6);
    done_pulse();
    ack_req(0);
    done_pulse();
    btn = '0;
    settle();

    // Retrigger of the playing id; a different press only queues
    btn[2] = 1'b1;
    push_exp(2, 0);
    wait_req(200);
    ack_req(2);
    a0 = abort_cnt;
    btn[2] = 1'b0;
    btn[1] = 1'b1;
    repeat ((DEB_TICKS + 1) * CLK_DIV + 4) @(negedge clk);
    chk("no_abort_on_queue", abort_cnt, a0);
    chk("btn1_queued", pending[1], 1);
    chk("no_req_on_queue", play_req, 0);
    btn[2] = 1'b1;
    push_exp(2, 1);
    wait_req(60);
    ack_req(2);
    push_exp(1, 0);
    done_pulse();
    ack_req(1);
    done_pulse();
    btn = '0;
    settle();

    // Low battery preempts a button sound; the button is not re-queued
    btn[4] = 1'b1;
    push_exp(4, 0);
    wait_req(200);
    ack_req(4);
    low_batt_btn = 1'b1;
    push_exp(8, 1);
    wait_req(60);
    ack_req(8);
    chk("btn4_not_requeued", pending[4], 0);
    chk("pending_empty_after_lb", pending, 0);
    done_pulse();
    repeat (8) @(negedge clk);
    chk("idle_after_lb", play_req, 0);
    low_batt_btn = 1'b0;
    btn[4] = 1'b0;
    settle();

    // Watchdog: no play_done -> abort, sticky timeout_err, back to IDLE
    btn[7] = 1'b1;
    push_exp(7, 0);
    wait_req(200);
    ack_req(7);
    chk("no_err_before_wd", timeout_err, 0);
    n = 0;
    while (!abort && n < (MAX_PLAY_TICKS + 3) * CLK_DIV) begin
      @(negedge clk);
      n++;
    end
    $display("[TB] watchdog abort after %0d cycles", n);
    chk("wd_abort", abort, 1);
    chk("wd_timing_in_range",
        int'(n >= (MAX_PLAY_TICKS - 1) * CLK_DIV - 1 && n <= MAX_PLAY_TICKS * CLK_DIV), 1);
    chk("wd_timeout_err", timeout_err, 1);
    chk("wd_req_low", play_req, 0);
    @(negedge clk);
    chk("abort_one_cycle", abort, 0);
    btn[7] = 1'b0;
    settle();
    chk("timeout_err_sticky", timeout_err, 1);

    // Reset while in REQ drops everything; held button yields one new press
    btn[6] = 1'b1;
    push_exp(6, 0);
    wait_req(200);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req_play_req", play_req, 0);
    chk("rst_req_abort", abort, 0);
    chk("rst_req_play_id", play_id, 0);
    chk("rst_req_pending", pending, 0);
    chk("rst_req_timeout_err", timeout_err, 0);
    chk("rst_req_sample_tick", sample_tick, 0);
    @(negedge clk);
    reset_n = 1'b1;
    push_exp(6, 0);
    wait_req(200);
    ack_req(6);
    done_pulse();
    btn[6] = 1'b0;
    settle();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
